// File: rtl/phy1_rx_frame_if.sv
// phy1_rx_frame_if: MII receive nibbles, receive-RAM write port and frame status handshake.
interface phy1_rx_frame_if;
  logic        phy1_rx_dv;
  logic [3:0]  phy1_rx;
  logic [10:0] rxmem_address;
  logic [7:0]  rxmem_data;
  logic        rxmem_wren;
  logic        rx_ready;
  logic [10:0] rx_length;
  logic        rx_err;
  logic        rx_ack;
  modport master (
    input  phy1_rx_dv, phy1_rx, rx_ack,
    output rxmem_address, rxmem_data, rxmem_wren, rx_ready, rx_length, rx_err
  );
  modport slave (
    output phy1_rx_dv, phy1_rx, rx_ack,
    input  rxmem_address, rxmem_data, rxmem_wren, rx_ready, rx_length, rx_err
  );
endinterface

// File: rtl/phy1_rx_frame.sv
// phy1_rx_frame: MII receive framer writing bytes to RAM with CRC-32 check and ready/ack status.
module phy1_rx_frame #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1522
) (
  input logic phy1_rx_clk,
  input logic rst,
  phy1_rx_frame_if.master bus
);
  typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, DONE, DROP} state_t;
  localparam logic [10:0] MAX_L   = 11'(MAX_LEN);
  localparam logic [10:0] MIN_L   = 11'(MIN_LEN);
  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction
  state_t      state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [31:0] crc_q, crc_d;
  logic [3:0]  nib_q, nib_d;
  logic        phase_q, phase_d;
  logic        ovf_q, ovf_d;
  logic        dv_prev_q, dv_prev_d;
  logic        wren_q, wren_d;
  logic [10:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        ready_q, ready_d;
  logic [10:0] len_q, len_d;
  logic        err_q, err_d;
  logic [7:0]  byte_w;
  logic        dv;
  logic [3:0]  nib;
  assign dv     = bus.phy1_rx_dv;
  assign nib    = bus.phy1_rx;
  assign byte_w = {nib, nib_q};
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    crc_d     = crc_q;
    nib_d     = nib_q;
    phase_d   = phase_q;
    ovf_d     = ovf_q;
    dv_prev_d = dv;
    wren_d    = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    ready_d   = ready_q;
    len_d     = len_q;
    err_d     = err_q;
    case (state_q)
      // A frame already in progress on the previous edge is never joined mid-stream.
      IDLE: if (dv) state_d = (nib == 4'h5 && !dv_prev_q) ? PREAMBLE : DROP;
      PREAMBLE: begin
        if (!dv) state_d = IDLE;
        else if (nib == 4'hD) begin
          state_d = DATA;
          cnt_d   = 11'd0;
          phase_d = 1'b0;
          crc_d   = 32'hFFFFFFFF;
          ovf_d   = 1'b0;
        end else if (nib != 4'h5) state_d = DROP;
      end
      DATA: begin
        if (dv && !phase_q) begin
          nib_d   = nib;
          phase_d = 1'b1;
        end else if (dv) begin
          phase_d = 1'b0;
          crc_d   = crc_byte(crc_q, byte_w);
          if (cnt_q < MAX_L) begin
            wren_d = 1'b1;
            addr_d = cnt_q;
            data_d = byte_w;
            cnt_d  = cnt_q + 11'd1;
          end else ovf_d = 1'b1;
        end else begin
          state_d = DONE;
          ready_d = 1'b1;
          len_d   = cnt_q;
          err_d   = ovf_q | phase_q | (cnt_q < MIN_L) | (crc_q != RESIDUE);
        end
      end
      DONE: if (bus.rx_ack) begin
        ready_d = 1'b0;
        state_d = dv ? DROP : IDLE;
      end
      DROP: if (!dv) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge phy1_rx_clk) begin
    dv_prev_q <= dv_prev_d;
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      crc_q   <= '0;
      nib_q   <= '0;
      phase_q <= 1'b0;
      ovf_q   <= 1'b0;
      wren_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      len_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      crc_q   <= crc_d;
      nib_q   <= nib_d;
      phase_q <= phase_d;
      ovf_q   <= ovf_d;
      wren_q  <= wren_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      len_q   <= len_d;
      err_q   <= err_d;
    end
  end
  assign bus.rxmem_wren    = wren_q;
  assign bus.rxmem_address = addr_q;
  assign bus.rxmem_data    = data_q;
  assign bus.rx_ready      = ready_q;
  assign bus.rx_length     = len_q;
  assign bus.rx_err        = err_q;
endmodule
